// File: rtl/vote_pkg.sv
// Shared types for the voting-machine result reader: sizes, FSM states, candidate index.
package vote_pkg;

   localparam int NUM_CANDIDATES = 4;
   localparam int LED_W          = 8;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      PRESS,
      RELEASE,
      FINISH
   } reader_state_t;

   typedef logic [1:0] cand_idx_t;

   localparam cand_idx_t LAST_CAND = cand_idx_t'(NUM_CANDIDATES - 1);

   // Candidate index to button vector (bit 0 = button1).
   function automatic logic [NUM_CANDIDATES-1:0] cand_onehot(input cand_idx_t k);
      cand_onehot    = '0;
      cand_onehot[k] = 1'b1;
   endfunction

endpackage

// File: rtl/vote_max_select.sv
// Combinational argmax over the four tallies with tie detect; lowest index wins on equal maxima.
// Only built when VOTE_READER_WINNER_EN is defined.
`ifdef VOTE_READER_WINNER_EN
module vote_max_select
   import vote_pkg::*;
(
   input  logic [NUM_CANDIDATES-1:0][LED_W-1:0] tally,
   output cand_idx_t                            winner,
   output logic                                 tie
);

   logic [LED_W-1:0] max_v;

   always_comb begin
      winner = '0;
      max_v  = tally[0];
      tie    = 1'b0;
      // Strict > keeps the earliest index on equal values.
      for (int i = 1; i < NUM_CANDIDATES; i++) begin
         if (tally[i] > max_v) begin
            max_v  = tally[i];
            winner = cand_idx_t'(i);
         end
      end
      for (int i = 0; i < NUM_CANDIDATES; i++) begin
         if ((cand_idx_t'(i) != winner) && (tally[i] == max_v))
            tie = 1'b1;
      end
   end

endmodule
`endif

// File: rtl/vote_result_reader.sv
// Result-readout controller: enters result mode, presses each candidate button, latches led tallies.
// Define VOTE_READER_WINNER_EN to also register winner/tie from the latched tallies.
module vote_result_reader
   import vote_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int GAP_CYCLES    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LED_W-1:0] led,
   output logic             mode,
   output logic             button1,
   output logic             button2,
   output logic             button3,
   output logic             button4,
   output logic             busy,
   output logic             done,
   output logic [LED_W-1:0] tally0,
   output logic [LED_W-1:0] tally1,
   output logic [LED_W-1:0] tally2,
   output logic [LED_W-1:0] tally3,
   output logic [1:0]       winner,
   output logic             tie
);

   localparam int MAXC = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

   reader_state_t                        state_q, state_d;
   logic [CW-1:0]                        cnt_q, cnt_d;
   cand_idx_t                            k_q, k_d;
   logic [NUM_CANDIDATES-1:0][LED_W-1:0] tally_q;
   logic [NUM_CANDIDATES-1:0]            btn_q;
   logic                                 latch;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      k_d     = k_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = ENTER;
               k_d     = '0;
            end
         end
         ENTER: begin
            if (cnt_q == GAP_LAST) begin
               state_d = PRESS;
               cnt_d   = '0;
            end
         end
         PRESS: begin
            if (cnt_q == SETTLE_LAST) begin
               latch   = 1'b1;
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (k_q == LAST_CAND) begin
                  state_d = FINISH;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = PRESS;
               end
            end
         end
         FINISH: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         tally_q <= '0;
         btn_q   <= '0;
         mode    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         mode    <= (state_d == ENTER) || (state_d == PRESS) || (state_d == RELEASE);
         busy    <= (state_d != IDLE);
         done    <= (state_d == FINISH);
         btn_q   <= (state_d == PRESS) ? cand_onehot(k_d) : '0;
         if (latch)
            tally_q[k_q] <= led;
      end
   end

   assign button1 = btn_q[0];
   assign button2 = btn_q[1];
   assign button3 = btn_q[2];
   assign button4 = btn_q[3];
   assign tally0  = tally_q[0];
   assign tally1  = tally_q[1];
   assign tally2  = tally_q[2];
   assign tally3  = tally_q[3];

`ifdef VOTE_READER_WINNER_EN
   cand_idx_t max_idx;
   logic      max_tie;

   vote_max_select u_max (
      .tally  (tally_q),
      .winner (max_idx),
      .tie    (max_tie)
   );

   // Tallies are stable for the whole last RELEASE, so capture on entry to FINISH.
   always_ff @(posedge clk) begin
      if (reset) begin
         winner <= '0;
         tie    <= 1'b0;
      end else if (state_d == FINISH) begin
         winner <= max_idx;
         tie    <= max_tie;
      end
   end
`else
   assign winner = '0;
   assign tie    = 1'b0;
`endif

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader: behavioural voting machine, cycle-exact readout checks.
module tb_vote_result_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [7:0] cnt_m [4];
   logic [7:0] led_a, led_b;

   logic       mode_a, b1_a, b2_a, b3_a, b4_a, busy_a, done_a, tie_a;
   logic [7:0] t0_a, t1_a, t2_a, t3_a;
   logic [1:0] win_a;
   logic       mode_b, b1_b, b2_b, b3_b, b4_b, busy_b, done_b, tie_b;
   logic [7:0] t0_b, t1_b, t2_b, t3_b;
   logic [1:0] win_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Voting machine: shows the selected candidate's count while in result mode.
   assign led_a = !mode_a ? 8'h00 : b1_a ? cnt_m[0] : b2_a ? cnt_m[1] :
                  b3_a ? cnt_m[2] : b4_a ? cnt_m[3] : 8'h00;
   assign led_b = !mode_b ? 8'h00 : b1_b ? cnt_m[0] : b2_b ? cnt_m[1] :
                  b3_b ? cnt_m[2] : b4_b ? cnt_m[3] : 8'h00;

   vote_result_reader dut_a (
      .clk(clk), .reset(reset), .start(start_a), .led(led_a),
      .mode(mode_a), .button1(b1_a), .button2(b2_a), .button3(b3_a), .button4(b4_a),
      .busy(busy_a), .done(done_a),
      .tally0(t0_a), .tally1(t1_a), .tally2(t2_a), .tally3(t3_a),
      .winner(win_a), .tie(tie_a)
   );

   vote_result_reader #(.SETTLE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .led(led_b),
      .mode(mode_b), .button1(b1_b), .button2(b2_b), .button3(b3_b), .button4(b4_b),
      .busy(busy_b), .done(done_b),
      .tally0(t0_b), .tally1(t1_b), .tally2(t2_b), .tally3(t3_b),
      .winner(win_b), .tie(tie_b)
   );

   logic [6:0]  obs_a, obs_b;
   logic [31:0] tal_a, tal_b;
   logic [2:0]  wt_a, wt_b;
   assign obs_a = {mode_a, busy_a, done_a, b4_a, b3_a, b2_a, b1_a};
   assign obs_b = {mode_b, busy_b, done_b, b4_b, b3_b, b2_b, b1_b};
   assign tal_a = {t3_a, t2_a, t1_a, t0_a};
   assign tal_b = {t3_b, t2_b, t1_b, t0_b};
   assign wt_a  = {tie_a, win_a};
   assign wt_b  = {tie_b, win_b};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Start in the current cycle (cycle 0) and check pins every cycle through busy falling.
   task automatic readout(input bit sel, input int s, input int g, input bit restart,
                          input int rst_at);
      int         done_c;
      int         lo;
      logic [6:0] exp;
      done_c = 1 + g + 4 * (s + g);
      chk("idle_c0", sel ? 32'(obs_b) : 32'(obs_a), 32'h0);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      for (int c = 1; c <= done_c + 1; c++) begin
         exp    = '0;
         exp[6] = (c < done_c);
         exp[5] = (c <= done_c);
         exp[4] = (c == done_c);
         for (int k = 0; k < 4; k++) begin
            lo     = 1 + g + k * (s + g);
            exp[k] = (c >= lo) && (c < lo + s);
         end
         chk($sformatf("%s_cyc%0d", sel ? "b" : "a", c),
             sel ? 32'(obs_b) : 32'(obs_a), 32'(exp));
         if (c == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_pins", 32'(obs_a), 32'h0);
            chk("rst_tally", tal_a, 32'h0);
            chk("rst_winner", 32'(wt_a), 32'h0);
            for (int q = 0; q < 60; q++) begin
               tick();
               chk("rst_quiet", 32'(obs_a), 32'h0);
            end
            return;
         end
         if (restart && (c == 10 || c == 50)) start_a = 1'b1;
         if (c <= done_c) tick();
         start_a = 1'b0;
      end
   endtask

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      cnt_m   = '{8'd3, 8'd1, 8'd0, 8'd2};
      tick();
      tick();
      reset = 1'b0;
      chk("reset_pins_a", 32'(obs_a), 32'h0);
      chk("reset_tally_a", tal_a, 32'h0);
      chk("reset_winner_a", 32'(wt_a), 32'h0);
      chk("reset_pins_b", 32'(obs_b), 32'h0);
      chk("reset_tally_b", tal_b, 32'h0);
      tick();

      // Counts 3,1,0,2: unique max at candidate 1.
      readout(1'b0, 16, 4, 1'b0, 0);
      chk("tally_3102", tal_a, 32'h02000103);
      chk("winner_3102", 32'(wt_a), 32'h0);

      // Model changes; tallies must hold until the next readout.
      cnt_m = '{8'd2, 8'd5, 8'd5, 8'd1};
      tick(); tick(); tick();
      chk("tally_hold", tal_a, 32'h02000103);

      // Re-pulsed start at cycles 10 and 50 is ignored.
      readout(1'b0, 16, 4, 1'b1, 0);
      chk("tally_2551", tal_a, 32'h01050502);
`ifdef VOTE_READER_WINNER_EN
      chk("winner_2551", 32'(wt_a), 32'h5);
`else
      chk("winner_2551", 32'(wt_a), 32'h0);
`endif

      // Back-to-back: start in the cycle busy falls.
      cnt_m = '{8'd7, 8'd8, 8'd9, 8'd200};
      readout(1'b0, 16, 4, 1'b0, 0);
      chk("tally_b2b", tal_a, 32'hC8090807);
`ifdef VOTE_READER_WINNER_EN
      chk("winner_b2b", 32'(wt_a), 32'h3);
`else
      chk("winner_b2b", 32'(wt_a), 32'h0);
`endif
      tick();

      // Minimum timing instance: done at cycle 10.
      cnt_m = '{8'd4, 8'd9, 8'd9, 8'd9};
      readout(1'b1, 1, 1, 1'b0, 0);
      chk("tally_min", tal_b, 32'h09090904);
`ifdef VOTE_READER_WINNER_EN
      chk("winner_min", 32'(wt_b), 32'h5);
`else
      chk("winner_min", 32'(wt_b), 32'h0);
`endif
      chk("tally_a_hold", tal_a, 32'hC8090807);
      tick();

      // Reset at cycle 30 while button2 is held.
      cnt_m = '{8'd3, 8'd1, 8'd0, 8'd2};
      readout(1'b0, 16, 4, 1'b0, 30);
      chk("rst_tally_b", tal_b, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vote_result_reader.md
# vote_result_reader

Result-readout controller for the voting machine. On a start request it switches the machine into result mode and presses each candidate button in turn. It samples the `led` count for each candidate and latches the four tallies. Optionally it also computes the winner. It sits between the system controller and the voting machine's `mode`/`button1..4`/`led` pins, as the reader end of that interface.

## Interface
- `SETTLE_CYCLES`, 16: cycles each button is held before `led` is sampled; must be ≥ 1.
- `GAP_CYCLES`, 4: idle cycles on mode entry and after each button release; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a readout.
- `led` in 8: count displayed by the voting machine.
- `mode` out 1: drives the machine's `mode`; 1 means result display.
- `button1`..`button4` out 1 each: candidate select, at most one high at a time.
- `busy` out 1: a readout is in progress.
- `done` out 1: one-cycle pulse when the tallies are valid.
- `tally0`..`tally3` out 8 each: latched count for candidates 1..4.
- `winner` out 2: index of the highest tally.
- `tie` out 1: another candidate equals the maximum.

## Operation
- All outputs are registered.
- Reset value of every output is 0.
- FSM states: IDLE, ENTER, PRESS, RELEASE, FINISH.
- IDLE:
  - `start`=1 moves to ENTER.
  - `busy`=1 and `mode`=1 from the next cycle.
  - The candidate index k is cleared to 0.
  - `start` while busy is ignored, with no queueing.
- ENTER: `mode`=1 with all buttons low for `GAP_CYCLES` cycles, then to PRESS.
- PRESS:
  - `button(k+1)`=1 for exactly `SETTLE_CYCLES` cycles.
  - On the final PRESS cycle the value of `led` is latched into `tally[k]`.
  - Then to RELEASE.
- RELEASE: all buttons low for `GAP_CYCLES` cycles.
  - If k<3: k increments, then to PRESS.
  - If k=3: to FINISH.
- FINISH:
  - One cycle; `done`=1 and `mode`=0.
  - `winner` and `tie` are updated in the same cycle.
  - Next cycle: IDLE with `busy`=0.
- The tallies hold their last values until the next readout overwrites them. They are not cleared at start.
- Tallies are stored unsigned, 8 bits, with no arithmetic on them.
- Reset mid-operation:
  - The next edge returns to IDLE.
  - `mode`=0, all buttons and `busy` go to 0.
  - Tallies are cleared and no `done` pulse is issued.
- One cycle-counter is shared by ENTER/PRESS/RELEASE. Its width is `$clog2(max(SETTLE_CYCLES,GAP_CYCLES)+1)`.

## Timing
- The start cycle is cycle 0.
- `mode` rises in cycle 1.
- The first button rises in cycle 1+`GAP_CYCLES`.
- Each candidate slot is `SETTLE_CYCLES`+`GAP_CYCLES` cycles.
- `done` pulses in cycle 1+`GAP_CYCLES`+4·(`SETTLE_CYCLES`+`GAP_CYCLES`).
- Defaults give cycle 85. `busy` falls one cycle later.
- A `start` in the cycle after `busy` falls is accepted.
- Buttons never overlap.
- Button edges never coincide with a `mode` edge.

## Configuration
- `VOTE_READER_WINNER_EN` defined:
  - A comparator over the four tallies produces `winner` and `tie`, registered in FINISH.
  - On equal maxima, the lowest index wins and `tie`=1.
- Not defined: `winner` and `tie` are tied to 0 and no comparator logic is built.

## Structure
- Shared package `vote_pkg`:
  - `NUM_CANDIDATES`=4 and `LED_W`=8.
  - State enum `reader_state_t`.
  - Candidate index type (2 bits).
- One sub-module, `vote_max_select`: combinational 4-input argmax plus tie detect. Instantiated only under `VOTE_READER_WINNER_EN`.

## Test plan
- Use a behavioural voting-machine model with counts 3,1,0,2 and pulse `start` → button pulses in order 1..4. Each pulse is 16 cycles long, starting at cycles 5,25,45,65. Then `done` at cycle 85, `tally0..3`=3,1,0,2, `winner`=0, `tie`=0.
- Counts 2,5,5,1 with the macro on → `winner`=1, `tie`=1. With the macro off → `winner`=0, `tie`=0.
- `start` re-pulsed at cycles 10 and 50 → ignored; exactly one `done`, still at cycle 85.
- Assert `reset` at cycle 30, during button2 → from cycle 31 `mode`=0, all buttons 0, `busy`=0, tallies 0, no `done` pulse.
- Run with `SETTLE_CYCLES`=1, `GAP_CYCLES`=1 → `done` at cycle 10, each button high for exactly 1 cycle, tallies correct.
- Model changes its counts between two readouts → the second readout's tallies reflect the new counts, and tallies hold between readouts.
